// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_e;

    localparam logic [XLEN-1:0] DIV_ZERO_Q   = '1;
    localparam logic [XLEN-1:0] OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide sequencer.
interface muldiv_sequencer_if
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
);
    logic             Start;
    logic [2:0]       Funct3;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Flush;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;

    modport master (output Start, Funct3, SrcA, SrcB, Flush, input Busy, Done, Result);
    modport slave  (input Start, Funct3, SrcA, SrcB, Flush, output Busy, Done, Result);
endinterface

// File: rtl/muldiv_core.sv
// Datapath for the iterative multiply/divide: shared accumulator, step logic,
// sign fixup and the Result register.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  muldiv_op_e       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             early,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               is_div, neg_a, neg_b, div_zero, overflow;
    logic [WIDTH-1:0]   abs_a, abs_b, early_val, quo, rem, sel;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic               div_borrow;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;

    always_comb begin
        is_div   = op_is_div(op);
        neg_a    = src_a[WIDTH-1] && (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        neg_b    = src_b[WIDTH-1] && (op inside {OP_MULH, OP_DIV, OP_REM});
        abs_a    = neg_a ? -src_a : src_a;
        abs_b    = neg_b ? -src_b : src_b;
        div_zero = is_div && (src_b == '0);
        overflow = (op inside {OP_DIV, OP_REM}) && (src_a == OVF_DIVIDEND) && (src_b == '1);
        early    = div_zero || overflow;

        if (div_zero) early_val = (op inside {OP_DIV, OP_DIVU}) ? DIV_ZERO_Q : src_a;
        else          early_val = (op == OP_DIV) ? OVF_DIVIDEND : '0;

        // Multiply: partial product in the high half, multiplier shifts out of the low half.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Divide: remainder in the high half, quotient bits shift into the low half.
        div_trial  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        div_borrow = div_trial[WIDTH];
        div_rem    = div_borrow ? acc_q[2*WIDTH-2:WIDTH-1] : div_trial[WIDTH-1:0];
        div_next   = {div_rem, acc_q[WIDTH-2:0], ~div_borrow};

        prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (op)
            OP_MUL:                      sel = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: sel = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:             sel = quo;
            default:                     sel = rem;
        endcase

        acc_d    = acc_q;
        opnd_d   = opnd_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        result_d = result_q;
        if (load) begin
            acc_d    = {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
            opnd_d   = is_div ? abs_b : abs_a;
            sign_a_d = neg_a;
            sign_b_d = neg_b;
        end else if (step) begin
            acc_d = is_div ? div_next : mul_next;
        end
        if (fix) result_d = early ? early_val : sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: FSM that stalls the pipeline and strobes the
// muldiv_core datapath through load, iterate and fixup phases.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    muldiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    muldiv_op_e       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             load, step, fix, early;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        // Flush wins over everything, including a Start arriving in IDLE.
        if (bus.Flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.Start) begin
                    op_d    = muldiv_op_e'(bus.Funct3);
                    a_d     = bus.SrcA;
                    b_d     = bus.SrcB;
                    state_d = ST_PREP;
                end
                ST_PREP: begin
                    load  = 1'b1;
                    cnt_d = '0;
                    fix   = early;
                    state_d = early ? ST_DONE : ST_CALC;
                end
                ST_CALC: begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
                end
                ST_FIX: begin
                    fix     = 1'b1;
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .fix    (fix),
        .op     (op_q),
        .src_a  (a_q),
        .src_b  (b_q),
        .early  (early),
        .result (bus.Result)
    );

    assign bus.Busy = (state_q == ST_PREP) || (state_q == ST_CALC) || (state_q == ST_FIX);
    assign bus.Done = (state_q == ST_DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [W-1:0] last_res;

    muldiv_sequencer_if #(.WIDTH(W)) bus();
    muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (op)
            3'b000: begin t = sa * sb; return t[31:0]; end
            3'b001: begin t = sa * sb; return t[63:32]; end
            3'b010: begin t = sa * ub; return t[63:32]; end
            3'b011: begin t = ua * ub; return t[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                t = sa / sb; return t[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                t = ua / ub; return t[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                t = sa % sb; return t[31:0];
            end
            default: begin
                if (b == 0) return a;
                t = ua % ub; return t[31:0];
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (op[2] && (b == 0)) return 2;
        if ((op == 3'b100 || op == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return W + 3;
    endfunction

    // Issues one op and watches Busy/Done for every cycle up to one past the expected Done.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input bit busy_start);
        int lat, done_cyc, bad_busy;
        logic [W-1:0] res;
        lat = exp_latency(op, a, b);
        done_cyc = -1;
        bad_busy = 0;
        res = 'x;
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = op; bus.SrcA = a; bus.SrcB = b;
        @(negedge clk);
        bus.Start = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.Busy !== ((c < lat) ? 1'b1 : 1'b0)) bad_busy++;
            if (bus.Done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (bus.Done === 1'b1 && c != lat) bad_busy++;
            if (c == lat) res = bus.Result;
            if (busy_start && c == 5 && lat > 6) begin
                bus.Start = 1'b1; bus.Funct3 = 3'($urandom_range(0, 7)); bus.SrcA = $urandom(); bus.SrcB = $urandom();
            end
            if (c == 6) bus.Start = 1'b0;
        end
        check_val({tag, "_done_cycle"}, done_cyc, lat);
        check_val({tag, "_busy_window"}, bad_busy, 0);
        check_val({tag, "_result"}, res, exp);
        check_val({tag, "_hold"}, bus.Result, exp);
        last_res = exp;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int dones;
        logic [2:0] op;
        logic [W-1:0] a, b;
        reset = 1'b1;
        bus.Start = 1'b0; bus.Funct3 = 3'b0; bus.SrcA = '0; bus.SrcB = '0; bus.Flush = 1'b0;
        last_res = '0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", bus.Busy, 0);
        check_val("rst_done", bus.Done, 0);
        check_val("rst_result", bus.Result, 0);
        reset = 1'b0;

        run_op("mul_7xm3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

        // Flush a divide in flight: no Done, Result untouched.
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = OP_DIV; bus.SrcA = 32'd100; bus.SrcB = 32'd7;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        bus.Flush = 1'b1;
        @(negedge clk);
        bus.Flush = 1'b0;
        check_val("flush_busy", bus.Busy, 0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done === 1'b1) dones++;
        end
        check_val("flush_no_done", dones, 0);
        check_val("flush_result_hold", bus.Result, last_res);
        run_op("mul_after_flush", OP_MUL, 32'd3, 32'd4, 32'd12, 1'b1);

        // Start and Flush together in IDLE: Start must be dropped.
        @(negedge clk);
        bus.Start = 1'b1; bus.Flush = 1'b1; bus.Funct3 = OP_MUL; bus.SrcA = 32'd9; bus.SrcB = 32'd9;
        @(negedge clk);
        bus.Start = 1'b0; bus.Flush = 1'b0;
        check_val("flush_start_busy", bus.Busy, 0);
        @(negedge clk);
        check_val("flush_start_idle", bus.Busy, 0);

        // Reset in the middle of CALC.
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = OP_MULHU; bus.SrcA = 32'hDEAD_BEEF; bus.SrcB = 32'h1234_5678;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (14) @(negedge clk);
        check_val("pre_rst_busy", bus.Busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_busy", bus.Busy, 0);
        check_val("midrst_done", bus.Done, 0);
        check_val("midrst_result", bus.Result, 0);
        reset = 1'b0;
        last_res = '0;

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op("rand", op, a, b, ref_model(op, a, b), (i % 4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

- Multi-cycle sequencer for the RV32M multiply/divide instructions (Funct7 = 0000001), which sit beside the single-cycle ALU in the execute stage.
- Accepts one operation from the execute stage and runs an iterative radix-2 shift-add multiply or restoring divide over WIDTH cycles.
- Holds the pipeline with Busy until a one-cycle Done pulse presents Result.
- Divide-by-zero and signed overflow complete early.

## Interface
- WIDTH, 32, operand and result width in bits.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only in IDLE.
- Funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  in  WIDTH  rs1 operand (multiplicand / dividend).
- SrcB  in  WIDTH  rs2 operand (multiplier / divisor).
- Flush  in  1  synchronous abort, from a branch or jump redirect.
- Busy  out  1  stall request to the IF/ID/EX enables.
- Done  out  1  one-cycle result-valid pulse.
- Result  out  WIDTH  result, held until the next accepted Start.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - When Start = 1, latch Funct3, SrcA and SrcB, then go to PREP.
  - Start in any other state is ignored.
- PREP:
  - Record operand signs. SrcA is signed for MULH, MULHSU, DIV and REM. SrcB is signed for MULH, DIV and REM.
  - Take absolute values of the signed operands; clear the iteration counter.
  - Divide with SrcB = 0 goes to DONE with these values:
    - DIV and DIVU: all ones.
    - REM and REMU: SrcA.
  - DIV or REM with SrcA = 100…0 and SrcB = all ones goes to DONE with these values:
    - DIV: 100…0.
    - REM: 0.
  - Otherwise go to CALC.
- CALC:
  - Runs exactly WIDTH iterations; the counter is $clog2(WIDTH)+1 bits.
  - Multiply: 2·WIDTH-bit accumulator; add the multiplicand when the multiplier LSB is 1, then shift right.
  - Divide: shift the remainder/quotient pair left, trial-subtract the divisor, restore if negative; quotient bit = !borrow.
  - Go to FIX after the iteration with counter = WIDTH-1.
- FIX:
  - Negate the 2·WIDTH-bit product when the operand signs differ (MULHU never negates).
  - Negate the quotient when the signs differ; the remainder takes the sign of the dividend.
  - Select the result:
    - MUL: low word of the product.
    - MULH, MULHSU, MULHU: high word of the product.
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
  - Register the selection into Result, then go to DONE.
- DONE: Done = 1 for this cycle only; return to IDLE.
- Busy = 1 in PREP, CALC and FIX; 0 in IDLE and DONE.
- Flush: from any state, next state is IDLE; no Done is issued and Result keeps its previous value. Flush has priority over Start and over the normal transition.
- reset: state IDLE, Busy 0, Done 0, Result 0, counter 0, internal registers 0.

## Timing
- Cycle 0 is the edge where Start is sampled in IDLE.
- Normal path:
  - PREP during cycle 1.
  - CALC during cycles 2 to WIDTH+1.
  - FIX during cycle WIDTH+2.
  - Done high during cycle WIDTH+3, which is cycle 35 for WIDTH = 32.
- Early path: PREP during cycle 1, Done high during cycle 2.
- Busy rises one cycle after Start is sampled and falls in the Done cycle, so the stalled instruction advances on the edge that ends the Done cycle.
- A new Start can be accepted at the earliest one cycle after Done (back-to-back period WIDTH+4).
- Flush and Start in the same IDLE cycle: Start is discarded.
- Result changes only on the edge that enters DONE.

## Structure
- Package muldiv_pkg contains:
  - A typedef enum for the M-op codes on Funct3.
  - A typedef enum logic [2:0] for the states.
  - Constants for the divide-by-zero quotient (all ones) and the overflow dividend (100…0).
- One sub-module, muldiv_core, contains the accumulator/remainder registers, the shift-add and trial-subtract step logic, and the sign fixup.
- muldiv_core is driven by phase strobes (load, step, fix) from the FSM in muldiv_sequencer.

## Test plan
- MUL with SrcA = 7, SrcB = 0xFFFFFFFD: Result = 0xFFFFFFEB. Done exactly 35 cycles after Start; Busy high for cycles 1 to 34.
- MULH with 0x80000000 × 0x80000000: Result = 0x40000000.
- MULHU with 0xFFFFFFFF × 0xFFFFFFFF: Result = 0xFFFFFFFE.
- Signed divide with SrcA = 0xFFFFFFF9 (-7) and SrcB = 2:
  - DIV: Result = 0xFFFFFFFD.
  - REM: Result = 0xFFFFFFFF.
- Early-completion cases, each with Done at cycle 2:
  - DIVU 5/0: Result = 0xFFFFFFFF.
  - REMU 5/0: Result = 5.
  - DIV 0x80000000 / 0xFFFFFFFF: Result = 0x80000000.
- Flush and busy-Start behaviour:
  - Flush at cycle 10 of a DIV: Busy 0 at cycle 11 and no Done.
  - The next Start (MUL 3 × 4) yields Result = 12.
  - A Start pulsed while Busy is ignored.
- reset asserted mid-CALC: Busy, Done and Result are all 0 on the next cycle.
